// File: rtl/data_memory_controller_pkg.sv
// Shared definitions for the execute-memory stage data memory controller.
// Holds bus widths, 32-bit word slice bounds, the sequencer state type and
// the wrapping address helper used for the second word of a 32-bit transfer.
package data_memory_controller_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned DWORD_W = 2 * DATA_W;

    // Slice bounds of the high and low 16-bit halves of a 32-bit value.
    localparam int unsigned WORD_HI_MSB = DWORD_W - 1;
    localparam int unsigned WORD_HI_LSB = DATA_W;
    localparam int unsigned WORD_LO_MSB = DATA_W - 1;
    localparam int unsigned WORD_LO_LSB = 0;

    // P_LO: pipeline second word pending; I_LO: interrupt second word pending.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P_LO = 2'd1,
        I_LO = 2'd2
    } state_t;

    // Second-word address; wraps 0xFFFF -> 0x0000.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
        return ADDR_W'(addr + ADDR_W'(1));
    endfunction

endpackage

// File: rtl/data_memory_controller_if.sv
// Bus between the memory-stage requesters (pipeline, interrupt unit), the
// controller and the data memory instance.
//   slave  : controller view (requests and memory read data in, controls out)
//   master : requester/memory view (drives requests and memory read data)
interface data_memory_controller_if;
    import data_memory_controller_pkg::*;

    // pipeline request
    logic                mem_read_unused_guard;
    logic                i_mem_read;
    logic                i_mem_write;
    logic                i_double;
    logic [ADDR_W-1:0]   i_address;
    logic [DWORD_W-1:0]  i_write_data;
    // interrupt unit push request
    logic                i_int_req;
    logic [ADDR_W-1:0]   i_int_address;
    logic [DWORD_W-1:0]  i_int_pc;
    // status back to requesters
    logic                o_stall;
    logic                o_int_ack;
    logic [DWORD_W-1:0]  o_read_data;
    // data memory port
    logic [ADDR_W-1:0]   o_dm_address;
    logic [DATA_W-1:0]   o_dm_write_data;
    logic                o_dm_read;
    logic                o_dm_write;
    logic [DATA_W-1:0]   i_dm_read_data;

    assign mem_read_unused_guard = 1'b0;

    modport slave (
        input  i_mem_read, i_mem_write, i_double, i_address, i_write_data,
        input  i_int_req, i_int_address, i_int_pc,
        input  i_dm_read_data,
        output o_stall, o_int_ack, o_read_data,
        output o_dm_address, o_dm_write_data, o_dm_read, o_dm_write
    );

    modport master (
        output i_mem_read, i_mem_write, i_double, i_address, i_write_data,
        output i_int_req, i_int_address, i_int_pc,
        output i_dm_read_data,
        input  o_stall, o_int_ack, o_read_data,
        input  o_dm_address, o_dm_write_data, o_dm_read, o_dm_write
    );

endinterface

// File: rtl/data_memory_controller.sv
// Sequences and arbitrates the 16-bit data memory between the pipeline
// (LDD/STD single word, PUSH/POP 32-bit PC) and the interrupt unit (32-bit
// PC push). 32-bit transfers become two consecutive accesses, high word
// first; the pipeline is stalled for the first. Interrupt pushes win, but
// pipe_pri grants the pipeline one access after every push.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset; forces every output to 0
//   bus     : requester/memory bus (slave modport), memory read is combinational
module data_memory_controller
    import data_memory_controller_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    data_memory_controller_if.slave   bus
);

    state_t              state, state_next;
    logic [DATA_W-1:0]   hi_word, hi_word_next;
    logic                pipe_pri, pipe_pri_next;
    logic                pipe_req;

    logic                stall_c;
    logic                int_ack_c;
    logic [DWORD_W-1:0]  read_data_c;
    logic [ADDR_W-1:0]   dm_address_c;
    logic [DATA_W-1:0]   dm_write_data_c;
    logic                dm_read_c;
    logic                dm_write_c;

    assign pipe_req = bus.i_mem_read | bus.i_mem_write;

    // State, captured high read word and pipeline-priority flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            hi_word  <= '0;
            pipe_pri <= 1'b0;
        end else begin
            state    <= state_next;
            hi_word  <= hi_word_next;
            pipe_pri <= pipe_pri_next;
        end
    end

    // Next state and memory-side controls; a write wins over a simultaneous read.
    always_comb begin
        state_next      = state;
        hi_word_next    = hi_word;
        pipe_pri_next   = pipe_pri;
        stall_c         = 1'b0;
        int_ack_c       = 1'b0;
        read_data_c     = '0;
        dm_address_c    = '0;
        dm_write_data_c = '0;
        dm_read_c       = 1'b0;
        dm_write_c      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.i_int_req && (!pipe_pri || !pipe_req)) begin
                    dm_address_c    = bus.i_int_address;
                    dm_write_data_c = bus.i_int_pc[WORD_HI_MSB:WORD_HI_LSB];
                    dm_write_c      = 1'b1;
                    stall_c         = 1'b1;
                    state_next      = I_LO;
                end else if (pipe_req) begin
                    dm_address_c = bus.i_address;
                    if (bus.i_mem_write) begin
                        dm_write_c      = 1'b1;
                        dm_write_data_c = bus.i_double ? bus.i_write_data[WORD_HI_MSB:WORD_HI_LSB]
                                                       : bus.i_write_data[WORD_LO_MSB:WORD_LO_LSB];
                    end else begin
                        dm_read_c = 1'b1;
                    end
                    if (bus.i_double) begin
                        stall_c    = 1'b1;
                        state_next = P_LO;
                        if (!bus.i_mem_write) begin
                            hi_word_next = bus.i_dm_read_data;
                        end
                    end else begin
                        pipe_pri_next = 1'b0;
                        if (!bus.i_mem_write) begin
                            read_data_c = {{DATA_W{1'b0}}, bus.i_dm_read_data};
                        end
                    end
                end
            end

            P_LO: begin
                // Pending interrupt waits; the pipeline finishes its low word.
                if (pipe_req) begin
                    dm_address_c = next_addr(bus.i_address);
                    if (bus.i_mem_write) begin
                        dm_write_c      = 1'b1;
                        dm_write_data_c = bus.i_write_data[WORD_LO_MSB:WORD_LO_LSB];
                    end else begin
                        dm_read_c   = 1'b1;
                        read_data_c = {hi_word, bus.i_dm_read_data};
                    end
                end
                pipe_pri_next = 1'b0;
                state_next    = IDLE;
            end

            I_LO: begin
                dm_address_c    = next_addr(bus.i_int_address);
                dm_write_data_c = bus.i_int_pc[WORD_LO_MSB:WORD_LO_LSB];
                dm_write_c      = 1'b1;
                int_ack_c       = 1'b1;
                stall_c         = 1'b1;
                pipe_pri_next   = 1'b1;
                state_next      = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is asserted.
    assign bus.o_stall         = i_rst_n & stall_c;
    assign bus.o_int_ack       = i_rst_n & int_ack_c;
    assign bus.o_dm_read       = i_rst_n & dm_read_c;
    assign bus.o_dm_write      = i_rst_n & dm_write_c;
    assign bus.o_read_data     = i_rst_n ? read_data_c     : '0;
    assign bus.o_dm_address    = i_rst_n ? dm_address_c    : '0;
    assign bus.o_dm_write_data = i_rst_n ? dm_write_data_c : '0;

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller with a 4K-word behavioural data
// memory (combinational read, write on rising edge). Inputs change 1 ns
// after the rising edge; outputs are checked on the falling edge.
module tb_data_memory_controller;
    import data_memory_controller_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [15:0] mem [0:4095];

    data_memory_controller_if bus();

    data_memory_controller dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.i_dm_read_data = mem[bus.o_dm_address[11:0]];

    always @(posedge clk) begin
        if (bus.o_dm_write) mem[bus.o_dm_address[11:0]] <= bus.o_dm_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.i_mem_read    = 1'b0;
        bus.i_mem_write   = 1'b0;
        bus.i_double      = 1'b0;
        bus.i_address     = '0;
        bus.i_write_data  = '0;
        bus.i_int_req     = 1'b0;
        bus.i_int_address = '0;
        bus.i_int_pc      = '0;
    endtask

    task automatic pipe(input logic rd, input logic wr, input logic dbl,
                        input logic [15:0] a, input logic [31:0] wd);
        bus.i_mem_read   = rd;
        bus.i_mem_write  = wr;
        bus.i_double     = dbl;
        bus.i_address    = a;
        bus.i_write_data = wd;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        idle_inputs();

        // Reset: outputs forced low even with a request present
        rst_n = 1'b0;
        pipe(1'b0, 1'b1, 1'b0, 16'h0040, 32'h0000_0077);
        #2;
        chk("rst_dm_write", 32'(bus.o_dm_write), 32'd0);
        chk("rst_stall",    32'(bus.o_stall),    32'd0);
        chk("rst_addr",     32'(bus.o_dm_address), 32'd0);
        idle_inputs();
        mid();
        rst_n = 1'b1;
        step();

        // No request in IDLE
        mid();
        chk("idle_dm_read",  32'(bus.o_dm_read),  32'd0);
        chk("idle_dm_write", 32'(bus.o_dm_write), 32'd0);
        chk("idle_rdata",    bus.o_read_data,     32'd0);

        // Single write then single read, never stalled
        step();
        pipe(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0000_0A00);
        mid();
        chk("sw_stall", 32'(bus.o_stall),         32'd0);
        chk("sw_addr",  32'(bus.o_dm_address),    32'h0010);
        chk("sw_wdata", 32'(bus.o_dm_write_data), 32'h0A00);
        step();
        chk("sw_mem", 32'(mem[12'h010]), 32'h0A00);
        pipe(1'b1, 1'b0, 1'b0, 16'h0010, 32'h0);
        mid();
        chk("sr_stall", 32'(bus.o_stall), 32'd0);
        chk("sr_rdata", bus.o_read_data,  32'h0000_0A00);
        step();

        // Double write 0x12345678 at 0x0020
        pipe(1'b0, 1'b1, 1'b1, 16'h0020, 32'h1234_5678);
        mid();
        chk("dw1_stall", 32'(bus.o_stall),         32'd1);
        chk("dw1_wdata", 32'(bus.o_dm_write_data), 32'h1234);
        step();
        mid();
        chk("dw2_stall", 32'(bus.o_stall),         32'd0);
        chk("dw2_addr",  32'(bus.o_dm_address),    32'h0021);
        chk("dw2_wdata", 32'(bus.o_dm_write_data), 32'h5678);
        step();
        chk("dw_mem_hi", 32'(mem[12'h020]), 32'h1234);
        chk("dw_mem_lo", 32'(mem[12'h021]), 32'h5678);

        // Double read back
        pipe(1'b1, 1'b0, 1'b1, 16'h0020, 32'h0);
        mid();
        chk("dr1_stall", 32'(bus.o_stall),   32'd1);
        chk("dr1_read",  32'(bus.o_dm_read), 32'd1);
        step();
        mid();
        chk("dr2_stall", 32'(bus.o_stall), 32'd0);
        chk("dr2_rdata", bus.o_read_data,  32'h1234_5678);
        step();

        // Interrupt push collides with a pipeline double read
        bus.i_int_req     = 1'b1;
        bus.i_int_address = 16'h0FFE;
        bus.i_int_pc      = 32'hAAAA_5555;
        mid();
        chk("ip1_stall", 32'(bus.o_stall),         32'd1);
        chk("ip1_ack",   32'(bus.o_int_ack),       32'd0);
        chk("ip1_addr",  32'(bus.o_dm_address),    32'h0FFE);
        chk("ip1_wdata", 32'(bus.o_dm_write_data), 32'hAAAA);
        step();
        mid();
        chk("ip2_ack",   32'(bus.o_int_ack),       32'd1);
        chk("ip2_stall", 32'(bus.o_stall),         32'd1);
        chk("ip2_addr",  32'(bus.o_dm_address),    32'h0FFF);
        chk("ip2_wdata", 32'(bus.o_dm_write_data), 32'h5555);
        step();
        bus.i_int_req = 1'b0;
        chk("ip_mem_hi", 32'(mem[12'hFFE]), 32'hAAAA);
        chk("ip_mem_lo", 32'(mem[12'hFFF]), 32'h5555);
        mid();
        chk("ip3_read",  32'(bus.o_dm_read),    32'd1);
        chk("ip3_addr",  32'(bus.o_dm_address), 32'h0020);
        chk("ip3_ack",   32'(bus.o_int_ack),    32'd0);
        step();
        mid();
        chk("ip4_rdata", bus.o_read_data, 32'h1234_5678);
        step();

        // Interrupt held with a pipeline single read: pipeline gets every third cycle
        pipe(1'b1, 1'b0, 1'b0, 16'h0010, 32'h0);
        bus.i_int_req     = 1'b1;
        bus.i_int_address = 16'h0100;
        bus.i_int_pc      = 32'hBEEF_0001;
        for (int i = 0; i < 6; i++) begin
            mid();
            chk($sformatf("alt%0d_stall", i), 32'(bus.o_stall),   (i % 3 != 2) ? 32'd1 : 32'd0);
            chk($sformatf("alt%0d_ack", i),   32'(bus.o_int_ack), (i % 3 == 1) ? 32'd1 : 32'd0);
            if (i % 3 == 2) chk($sformatf("alt%0d_rdata", i), bus.o_read_data, 32'h0000_0A00);
            step();
        end
        idle_inputs();
        step();

        // Double write then read at 0xFFFF: second word wraps to 0x0000
        pipe(1'b0, 1'b1, 1'b1, 16'hFFFF, 32'hCAFE_F00D);
        mid();
        chk("wr1_addr", 32'(bus.o_dm_address), 32'hFFFF);
        step();
        mid();
        chk("wr2_addr", 32'(bus.o_dm_address), 32'h0000);
        step();
        chk("wr_mem_hi", 32'(mem[12'hFFF]), 32'hCAFE);
        chk("wr_mem_lo", 32'(mem[12'h000]), 32'hF00D);
        pipe(1'b1, 1'b0, 1'b1, 16'hFFFF, 32'h0);
        step();
        mid();
        chk("wrr_rdata", bus.o_read_data, 32'hCAFE_F00D);
        step();

        // Read and write together: write performed, no read data
        pipe(1'b1, 1'b1, 1'b0, 16'h0030, 32'h0000_0055);
        mid();
        chk("rw_write", 32'(bus.o_dm_write), 32'd1);
        chk("rw_read",  32'(bus.o_dm_read),  32'd0);
        chk("rw_rdata", bus.o_read_data,     32'd0);
        step();
        chk("rw_mem", 32'(mem[12'h030]), 32'h0055);

        // Reset asserted during P_LO of a double read
        pipe(1'b1, 1'b0, 1'b1, 16'h0020, 32'h0);
        step();
        mid();
        chk("rp_pre_state", 32'(dut.state), 32'(P_LO));
        rst_n = 1'b0;
        #1;
        chk("rp_stall", 32'(bus.o_stall),   32'd0);
        chk("rp_read",  32'(bus.o_dm_read), 32'd0);
        chk("rp_rdata", bus.o_read_data,    32'd0);
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        chk("rp_state", 32'(dut.state),   32'(IDLE));
        chk("rp_hi",    32'(dut.hi_word), 32'd0);

        // Reset asserted during I_LO: no ack, low word never written
        bus.i_int_req     = 1'b1;
        bus.i_int_address = 16'h0200;
        bus.i_int_pc      = 32'h1111_2222;
        step();
        mid();
        rst_n = 1'b0;
        #1;
        chk("ri_ack",   32'(bus.o_int_ack),  32'd0);
        chk("ri_write", 32'(bus.o_dm_write), 32'd0);
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        chk("ri_mem_hi", 32'(mem[12'h200]), 32'h1111);
        chk("ri_mem_lo", 32'(mem[12'h201]), 32'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
